memarb: RTL and testbench
=========================

Name: memarb

Overview:
Arbitrates a single shared memory port between the instruction-fetch requester (port F) and the load/store requester (port D) of the core. Used when imem and dmem are merged into one unified memory.
- Port D has fixed priority over port F.
- A starvation guard forces a grant to port F after repeated losses.
- At most one transaction is outstanding at any time; the response is routed back to the requester that issued it.

Parameters:
STARVE_LIMIT, 4, consecutive D grants while F is waiting before F is forced to win (range 1..15)
AW, 32, address width

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_f_valid  in  1  fetch request valid (read only)
i_f_addr  in  AW  fetch address
o_f_ready  out  1  fetch request accepted this cycle
o_f_rsp_valid  out  1  fetch response valid (one-cycle pulse)
o_f_rsp_data  out  32  fetch response data
i_d_valid  in  1  data request valid
i_d_addr  in  AW  data address
i_d_w_en  in  1  1 = store, 0 = load
i_d_w_data  in  32  store data
i_d_fmt  in  3  access format (funct3 encoding), passed through
o_d_ready  out  1  data request accepted this cycle
o_d_rsp_valid  out  1  data response valid (one-cycle pulse; also acks stores)
o_d_rsp_data  out  32  load data (0 for stores)
o_mem_req  out  1  memory request valid
o_mem_addr  out  AW  memory address
o_mem_w_en  out  1  memory write enable
o_mem_w_data  out  32  memory write data
o_mem_fmt  out  3  memory access format (fetch uses 3'b010, word)
i_mem_ready  in  1  memory accepts request
i_mem_rsp_valid  in  1  memory response valid (loads and stores)
i_mem_rsp_data  in  32  memory response data
o_err  out  1  sticky: unexpected memory response seen

Behaviour:
- Reset (async, active-high): state=IDLE, owner=F, starve_cnt=0, o_err=0.
  - All valid/ready outputs are 0, o_f_rsp_data=0, o_d_rsp_data=0.
  - Reset mid-transaction drops the outstanding transaction; no response is delivered for it.
- FSM states: IDLE, WAIT.
- IDLE:
  - Winner select (combinational):
    - starve_cnt==STARVE_LIMIT and i_f_valid -> F.
    - else i_d_valid -> D.
    - else i_f_valid -> F.
    - else none.
  - o_mem_req = 1 if there is a winner. o_mem_addr/w_en/w_data/fmt are muxed from the winner; a fetch drives w_en=0, w_data=0, fmt=3'b010.
  - With no winner, the o_mem_* data fields are 0.
  - On o_mem_req & i_mem_ready: winner's o_x_ready=1 in the same cycle; owner<=winner; next state WAIT.
  - If i_mem_ready=0, no ready is asserted and arbitration is re-evaluated next cycle. Requesters hold their request stable until ready.
- WAIT:
  - o_mem_req=0 and both o_x_ready=0.
  - On i_mem_rsp_valid: next cycle the owner's o_x_rsp_valid=1 for exactly one cycle, with registered data. D stores give rsp_data=0. Next state IDLE.
  - A new grant may occur in the same cycle the response pulse is presented.
- Response data registers hold their value until the next response to that port.
- starve_cnt is updated on each accepted grant:
  - D granted while i_f_valid=1 -> starve_cnt+1, saturating at STARVE_LIMIT.
  - F granted -> starve_cnt=0.
  - D granted with i_f_valid=0 -> starve_cnt unchanged.
- i_mem_rsp_valid in IDLE is ignored for routing and sets o_err=1 (sticky until reset).
- Throughput: one transaction per 2 cycles minimum with zero memory latency (accept cycle + response cycle).
- Latency: request to response pulse = 1 + memory latency + 1 cycles.

Test Plan:
- Fetch only: F valid with addr 0x00000010, memory ready, response 0x12300013 one cycle after accept -> o_f_ready pulses in cycle 0; o_f_rsp_valid=1 with data 0x12300013 two cycles after accept; D outputs stay 0.
- Simultaneous request: F and D both valid, D is a load of 0x100 returning 0xDEADBEEF -> D granted first, F stalled with o_f_ready=0; after the D response, F is granted on the next IDLE cycle.
- Starvation with STARVE_LIMIT=4: D continuously valid, F continuously valid -> D wins 4 grants, the 5th grant goes to F, starve_cnt returns to 0, and D wins the next grant.
- Store ack: D store to 0x20, w_data 0xA5A5A5A5, fmt 3'b000 -> o_mem_w_en=1, o_mem_fmt=000, o_mem_w_data=0xA5A5A5A5; after the memory response, o_d_rsp_valid pulses with data 0.
- Backpressure and reset: i_mem_ready=0 for 3 cycles -> o_mem_req held with fields stable and no ready asserted; assert i_rst during WAIT -> all outputs return to 0 and no response is delivered; a later i_mem_rsp_valid while IDLE -> o_err=1 and stays 1.

Source files
------------

// File: rtl/memarb.sv
`default_nettype none
// ============================================================================
// Module   : memarb
// Purpose  : Arbitrates one shared memory port between the instruction-fetch
//            requester (F) and the load/store requester (D). D has fixed
//            priority; a starvation guard forces F to win once D has taken
//            STARVE_LIMIT consecutive grants while F was waiting. Only one
//            transaction is outstanding at a time, and its response is routed
//            back to the requester that issued it.
// Ports    :
//   i_clk, i_rst                 clock, asynchronous active-high reset
//   i_f_valid/i_f_addr           fetch request (read only)
//   o_f_ready                    fetch request accepted this cycle
//   o_f_rsp_valid/o_f_rsp_data   fetch response (one-cycle pulse)
//   i_d_valid/i_d_addr/i_d_w_en/i_d_w_data/i_d_fmt   data request
//   o_d_ready                    data request accepted this cycle
//   o_d_rsp_valid/o_d_rsp_data   data response (stores ack with data 0)
//   o_mem_*                      shared memory request
//   i_mem_ready                  memory accepts request
//   i_mem_rsp_valid/i_mem_rsp_data  memory response
//   o_err                        sticky: response seen with nothing outstanding
// Revision : 1.0 - initial release
// ============================================================================
module memarb #(
  parameter int STARVE_LIMIT = 4,
  parameter int AW           = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_f_valid,
  input  logic [AW-1:0] i_f_addr,
  output logic          o_f_ready,
  output logic          o_f_rsp_valid,
  output logic [31:0]   o_f_rsp_data,
  input  logic          i_d_valid,
  input  logic [AW-1:0] i_d_addr,
  input  logic          i_d_w_en,
  input  logic [31:0]   i_d_w_data,
  input  logic [2:0]    i_d_fmt,
  output logic          o_d_ready,
  output logic          o_d_rsp_valid,
  output logic [31:0]   o_d_rsp_data,
  output logic          o_mem_req,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_w_en,
  output logic [31:0]   o_mem_w_data,
  output logic [2:0]    o_mem_fmt,
  input  logic          i_mem_ready,
  input  logic          i_mem_rsp_valid,
  input  logic [31:0]   i_mem_rsp_data,
  output logic          o_err
);

  localparam logic [3:0] LIMIT     = 4'(STARVE_LIMIT);
  localparam logic [2:0] FMT_WORD  = 3'b010;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t      state, next_state;
  logic        owner_d;      // 1: outstanding transaction belongs to D
  logic        d_store;      // outstanding D transaction is a store
  logic [3:0]  starve_cnt;
  logic        pick_f, pick_d;
  logic        grant_f, grant_d;
  logic        f_rsp_valid, d_rsp_valid;
  logic [31:0] f_rsp_data, d_rsp_data;
  logic        err;

  // Arbitration and memory-side request mux
  always_comb begin
    next_state   = state;
    pick_f       = 1'b0;
    pick_d       = 1'b0;
    grant_f      = 1'b0;
    grant_d      = 1'b0;
    o_mem_addr   = '0;
    o_mem_w_en   = 1'b0;
    o_mem_w_data = '0;
    o_mem_fmt    = '0;
    case (state)
      IDLE: begin
        // Starvation guard overrides D priority only when F is actually waiting
        if (starve_cnt == LIMIT && i_f_valid) begin
          pick_f = 1'b1;
        end else if (i_d_valid) begin
          pick_d = 1'b1;
        end else if (i_f_valid) begin
          pick_f = 1'b1;
        end

        if (pick_f) begin
          o_mem_addr = i_f_addr;
          o_mem_fmt  = FMT_WORD;
        end else if (pick_d) begin
          o_mem_addr   = i_d_addr;
          o_mem_w_en   = i_d_w_en;
          o_mem_w_data = i_d_w_data;
          o_mem_fmt    = i_d_fmt;
        end

        if (i_mem_ready && !i_rst && (pick_f || pick_d)) begin
          grant_f    = pick_f;
          grant_d    = pick_d;
          next_state = WAIT;
        end
      end
      WAIT: begin
        if (i_mem_rsp_valid) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Handshake outputs are forced low while reset is held
  assign o_mem_req = (pick_f | pick_d) & ~i_rst;
  assign o_f_ready = grant_f;
  assign o_d_ready = grant_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Ownership and starvation counter, updated only on accepted grants
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      owner_d    <= 1'b0;
      d_store    <= 1'b0;
      starve_cnt <= '0;
    end else if (grant_f) begin
      owner_d    <= 1'b0;
      starve_cnt <= '0;
    end else if (grant_d) begin
      owner_d <= 1'b1;
      d_store <= i_d_w_en;
      if (i_f_valid && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Response routing; data registers hold until the next response to that port
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      f_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      f_rsp_data  <= '0;
      d_rsp_data  <= '0;
      err         <= 1'b0;
    end else begin
      f_rsp_valid <= 1'b0;
      d_rsp_valid <= 1'b0;
      if (i_mem_rsp_valid) begin
        if (state == WAIT) begin
          if (owner_d) begin
            d_rsp_valid <= 1'b1;
            d_rsp_data  <= d_store ? 32'd0 : i_mem_rsp_data;
          end else begin
            f_rsp_valid <= 1'b1;
            f_rsp_data  <= i_mem_rsp_data;
          end
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

  assign o_f_rsp_valid = f_rsp_valid;
  assign o_f_rsp_data  = f_rsp_data;
  assign o_d_rsp_valid = d_rsp_valid;
  assign o_d_rsp_data  = d_rsp_data;
  assign o_err         = err;

endmodule
`default_nettype wire

// File: tb/tb_memarb.sv
`default_nettype none
// ============================================================================
// Module   : tb_memarb
// Purpose  : Directed self-checking bench for memarb (STARVE_LIMIT=4, AW=32).
//            Inputs change 1 time unit after the rising edge; outputs are
//            checked 1 more unit later, well away from the next edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memarb;

  logic        clk = 1'b0;
  logic        rst;
  logic        f_valid;
  logic [31:0] f_addr;
  logic        f_ready;
  logic        f_rsp_valid;
  logic [31:0] f_rsp_data;
  logic        d_valid;
  logic [31:0] d_addr;
  logic        d_w_en;
  logic [31:0] d_w_data;
  logic [2:0]  d_fmt;
  logic        d_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_w_en;
  logic [31:0] mem_w_data;
  logic [2:0]  mem_fmt;
  logic        mem_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        err;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  memarb #(.STARVE_LIMIT(4), .AW(32)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_f_valid      (f_valid),
    .i_f_addr       (f_addr),
    .o_f_ready      (f_ready),
    .o_f_rsp_valid  (f_rsp_valid),
    .o_f_rsp_data   (f_rsp_data),
    .i_d_valid      (d_valid),
    .i_d_addr       (d_addr),
    .i_d_w_en       (d_w_en),
    .i_d_w_data     (d_w_data),
    .i_d_fmt        (d_fmt),
    .o_d_ready      (d_ready),
    .o_d_rsp_valid  (d_rsp_valid),
    .o_d_rsp_data   (d_rsp_data),
    .o_mem_req      (mem_req),
    .o_mem_addr     (mem_addr),
    .o_mem_w_en     (mem_w_en),
    .o_mem_w_data   (mem_w_data),
    .o_mem_fmt      (mem_fmt),
    .i_mem_ready    (mem_ready),
    .i_mem_rsp_valid(mem_rsp_valid),
    .i_mem_rsp_data (mem_rsp_data),
    .o_err          (err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; f_valid = 0; f_addr = 0; d_valid = 0; d_addr = 0; d_w_en = 0;
    d_w_data = 0; d_fmt = 0; mem_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0;
    tick(); tick();
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_f_rsp_valid", 32'(f_rsp_valid), 32'd0);
    chk("rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    chk("rst_f_rsp_data", f_rsp_data, 32'd0);
    chk("rst_d_rsp_data", d_rsp_data, 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    // ---- Fetch only ----
    tick();
    f_valid = 1; f_addr = 32'h10; mem_ready = 1;
    #1;
    chk("f_mem_req", 32'(mem_req), 32'd1);
    chk("f_mem_addr", mem_addr, 32'h10);
    chk("f_mem_fmt", 32'(mem_fmt), 32'd2);
    chk("f_mem_w_en", 32'(mem_w_en), 32'd0);
    chk("f_ready", 32'(f_ready), 32'd1);
    chk("f_d_ready", 32'(d_ready), 32'd0);
    tick();
    f_valid = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h12300013;
    #1;
    chk("f_wait_req", 32'(mem_req), 32'd0);
    chk("f_wait_rsp", 32'(f_rsp_valid), 32'd0);
    tick();
    mem_rsp_valid = 0;
    #1;
    chk("f_rsp_valid", 32'(f_rsp_valid), 32'd1);
    chk("f_rsp_data", f_rsp_data, 32'h12300013);
    chk("f_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
    chk("f_d_rsp_data", d_rsp_data, 32'd0);
    tick();
    #1;
    chk("f_rsp_pulse_end", 32'(f_rsp_valid), 32'd0);
    chk("f_rsp_data_hold", f_rsp_data, 32'h12300013);

    // ---- Simultaneous F and D: D first, then F ----
    f_valid = 1; f_addr = 32'h14;
    d_valid = 1; d_addr = 32'h100; d_w_en = 0; d_fmt = 3'b010;
    #1;
    chk("sim_d_ready", 32'(d_ready), 32'd1);
    chk("sim_f_ready", 32'(f_ready), 32'd0);
    chk("sim_addr", mem_addr, 32'h100);
    tick();
    d_valid = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hDEADBEEF;
    #1;
    chk("sim_wait_f_ready", 32'(f_ready), 32'd0);
    tick();
    mem_rsp_valid = 0;
    #1;
    chk("sim_d_rsp_valid", 32'(d_rsp_valid), 32'd1);
    chk("sim_d_rsp_data", d_rsp_data, 32'hDEADBEEF);
    chk("sim_f_rsp_valid", 32'(f_rsp_valid), 32'd0);
    chk("sim_f_ready2", 32'(f_ready), 32'd1);
    chk("sim_addr2", mem_addr, 32'h14);
    tick();
    f_valid = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h00000093;
    tick();
    mem_rsp_valid = 0;
    #1;
    chk("sim_f_rsp_valid2", 32'(f_rsp_valid), 32'd1);
    chk("sim_f_rsp_data2", f_rsp_data, 32'h00000093);
    chk("sim_d_rsp_hold", d_rsp_data, 32'hDEADBEEF);

    // ---- Starvation guard: D,D,D,D,F,D ----
    tick();
    f_valid = 1; f_addr = 32'h40;
    d_valid = 1; d_addr = 32'h200;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("starve_d_ready_%0d", i), 32'(d_ready), (i == 4) ? 32'd0 : 32'd1);
      chk($sformatf("starve_f_ready_%0d", i), 32'(f_ready), (i == 4) ? 32'd1 : 32'd0);
      if (i > 0) begin
        chk($sformatf("starve_d_rsp_%0d", i), 32'(d_rsp_valid), (i == 5) ? 32'd0 : 32'd1);
        chk($sformatf("starve_f_rsp_%0d", i), 32'(f_rsp_valid), (i == 5) ? 32'd1 : 32'd0);
      end
      tick();
      mem_rsp_valid = 1; mem_rsp_data = 32'(i + 1);
      tick();
      mem_rsp_valid = 0;
    end
    f_valid = 0; d_valid = 0;
    #1;
    chk("starve_last_d_rsp", 32'(d_rsp_valid), 32'd1);
    chk("starve_last_d_data", d_rsp_data, 32'd6);
    chk("starve_f_data", f_rsp_data, 32'd5);

    // ---- Store ack ----
    tick();
    d_valid = 1; d_addr = 32'h20; d_w_en = 1; d_w_data = 32'hA5A5A5A5; d_fmt = 3'b000;
    #1;
    chk("st_w_en", 32'(mem_w_en), 32'd1);
    chk("st_fmt", 32'(mem_fmt), 32'd0);
    chk("st_w_data", mem_w_data, 32'hA5A5A5A5);
    chk("st_addr", mem_addr, 32'h20);
    chk("st_d_ready", 32'(d_ready), 32'd1);
    tick();
    d_valid = 0; d_w_en = 0; mem_rsp_valid = 1; mem_rsp_data = 32'hFFFFFFFF;
    tick();
    mem_rsp_valid = 0;
    #1;
    chk("st_rsp_valid", 32'(d_rsp_valid), 32'd1);
    chk("st_rsp_data", d_rsp_data, 32'd0);

    // ---- Backpressure, reset during WAIT, unexpected response ----
    tick();
    mem_ready = 0; f_valid = 1; f_addr = 32'h80;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_req_%0d", i), 32'(mem_req), 32'd1);
      chk($sformatf("bp_addr_%0d", i), mem_addr, 32'h80);
      chk($sformatf("bp_f_ready_%0d", i), 32'(f_ready), 32'd0);
      tick();
    end
    mem_ready = 1;
    #1;
    chk("bp_f_ready_go", 32'(f_ready), 32'd1);
    tick();
    rst = 1;
    #1;
    chk("rw_mem_req", 32'(mem_req), 32'd0);
    chk("rw_f_ready", 32'(f_ready), 32'd0);
    chk("rw_d_ready", 32'(d_ready), 32'd0);
    chk("rw_f_rsp_data", f_rsp_data, 32'd0);
    chk("rw_d_rsp_data", d_rsp_data, 32'd0);
    tick();
    rst = 0; f_valid = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h55;
    #1;
    chk("err_before", 32'(err), 32'd0);
    tick();
    mem_rsp_valid = 0;
    #1;
    chk("err_set", 32'(err), 32'd1);
    chk("err_no_f_rsp", 32'(f_rsp_valid), 32'd0);
    chk("err_no_f_data", f_rsp_data, 32'd0);
    tick(); tick();
    #1;
    chk("err_sticky", 32'(err), 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
